// File: rtl/pcm_i2s_tx_pkg.sv
// Shared I2S transmitter definitions: FSM states and default frame format.
package pcm_i2s_tx_pkg;

  localparam int unsigned I2S_DW       = 32;
  localparam int unsigned I2S_BCK_HALF = 4;
  localparam int unsigned I2S_DIV_W    = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } tx_state_e;

endpackage

// File: rtl/i2s_bck_gen.sv
// Bit-clock generator: pclk divider, bick toggle and bit index within the frame.
module i2s_bck_gen
  import pcm_i2s_tx_pkg::*;
#(
  parameter int unsigned BCK_HALF = I2S_BCK_HALF,
  parameter int unsigned DW       = I2S_DW
) (
  input  logic                      pclk,
  input  logic                      preset_n,
  input  logic                      run_i,
  output logic                      bick_o,
  output logic [$clog2(2*DW)-1:0]   k_o,
  output logic                      rise_c_o,
  output logic                      fall_c_o,
  output logic                      wrap_c_o
);

  localparam int unsigned KW = $clog2(2*DW);

  logic [I2S_DIV_W-1:0] div_q, div_d;
  logic                 bick_q, bick_d;
  logic [KW-1:0]        k_q, k_d;
  logic                 tick_c;

  // Divider wrap toggles bick; bit index steps on each falling edge. All held at 0 while stopped.
  always_comb begin
    tick_c   = run_i && (div_q == I2S_DIV_W'(BCK_HALF - 1));
    rise_c_o = tick_c && !bick_q;
    fall_c_o = tick_c && bick_q;
    wrap_c_o = fall_c_o && (k_q == KW'(2*DW - 1));
    div_d    = '0;
    bick_d   = 1'b0;
    k_d      = '0;
    if (run_i) begin
      div_d  = tick_c ? '0 : div_q + I2S_DIV_W'(1);
      bick_d = bick_q ^ tick_c;
      k_d    = k_q;
      if (fall_c_o) begin
        k_d = wrap_c_o ? '0 : k_q + KW'(1);
      end
    end
  end

  // Divider, bit clock and bit index registers.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      div_q  <= '0;
      bick_q <= 1'b0;
      k_q    <= '0;
    end else begin
      div_q  <= div_d;
      bick_q <= bick_d;
      k_q    <= k_d;
    end
  end

  assign bick_o = bick_q;
  assign k_o    = k_q;

endmodule

// File: rtl/pcm_i2s_tx.sv
// PCM stereo sample to I2S serial transmitter with one-deep holding register.
module pcm_i2s_tx
  import pcm_i2s_tx_pkg::*;
#(
  parameter int unsigned BCK_HALF = I2S_BCK_HALF,
  parameter int unsigned DW       = I2S_DW
) (
  input  logic          pclk,
  input  logic          preset_n,
  input  logic          en,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_l,
  input  logic [DW-1:0] in_r,
  output logic          bick,
  output logic          lrck,
  output logic          sdata,
  output logic          frame_start,
  output logic          underrun
);

  localparam int unsigned FW = 2*DW;
  localparam int unsigned KW = $clog2(FW);

  tx_state_e     state_q, state_d;
  logic [FW-1:0] shreg_q, shreg_d;
  logic [FW-1:0] hold_q, hold_d;
  logic          hold_full_q, hold_full_d;
  logic          lrck_q, lrck_d;
  logic          sdata_q, sdata_d;
  logic          fs_q, fs_d;
  logic          underrun_q, underrun_d;

  logic          run_c, rise_c, fall_c, wrap_c;
  logic          entry_c, load_c, accept_c;
  logic [KW-1:0] k_c;

  i2s_bck_gen #(
    .BCK_HALF (BCK_HALF),
    .DW       (DW)
  ) u_bck_gen (
    .pclk     (pclk),
    .preset_n (preset_n),
    .run_i    (run_c),
    .bick_o   (bick),
    .k_o      (k_c),
    .rise_c_o (rise_c),
    .fall_c_o (fall_c),
    .wrap_c_o (wrap_c)
  );

  // Starting from IDLE counts as a frame boundary so the first frame carries held data.
  assign run_c    = (state_q == ST_RUN);
  assign entry_c  = (state_q == ST_IDLE) && en;
  assign load_c   = entry_c || (wrap_c && en);
  assign in_ready = !hold_full_q || load_c;
  assign accept_c = in_valid && in_ready;

  // Next-state for FSM, serializer, holding register and flags.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    lrck_d      = lrck_q;
    sdata_d     = sdata_q;
    fs_d        = 1'b0;
    underrun_d  = underrun_q;

    case (state_q)
      ST_IDLE: if (en) state_d = ST_RUN;
      ST_RUN:  if (wrap_c && !en) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (fall_c) begin
      sdata_d = shreg_q[FW-1];
      shreg_d = {shreg_q[FW-2:0], 1'b0};
      if (k_c == KW'(DW - 1)) lrck_d = 1'b1;
      if (wrap_c)             lrck_d = 1'b0;
      if (wrap_c && !en)      sdata_d = 1'b0;
    end

    if (load_c) begin
      shreg_d     = hold_full_q ? hold_q : '0;
      hold_full_d = 1'b0;
      fs_d        = 1'b1;
      if (!hold_full_q) underrun_d = 1'b1;
    end

    if (accept_c) begin
      hold_d      = {in_l, in_r};
      hold_full_d = 1'b1;
    end

    if (state_q == ST_IDLE) begin
      lrck_d  = 1'b0;
      sdata_d = 1'b0;
    end
  end

  // State, data and output registers.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      lrck_q      <= 1'b0;
      sdata_q     <= 1'b0;
      fs_q        <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      lrck_q      <= lrck_d;
      sdata_q     <= sdata_d;
      fs_q        <= fs_d;
      underrun_q  <= underrun_d;
    end
  end

  // A rising strobe must always find the bit clock low.
  a_rise_from_low: assert property (@(posedge pclk) disable iff (!preset_n) rise_c |-> !bick);

  assign lrck        = lrck_q;
  assign sdata       = sdata_q;
  assign frame_start = fs_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_pcm_i2s_tx.sv
// Self-checking bench for pcm_i2s_tx: I2S receiver model plus frame scoreboard.
module tb_pcm_i2s_tx;

  localparam int unsigned BCK_HALF = 4;
  localparam int unsigned DW       = 32;
  localparam int unsigned FW       = 2*DW;

  logic          pclk = 1'b0;
  logic          preset_n = 1'b1;
  logic          en = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_l = '0;
  logic [DW-1:0] in_r = '0;
  logic          bick, lrck, sdata, frame_start, underrun;

  pcm_i2s_tx #(.BCK_HALF(BCK_HALF), .DW(DW)) dut (
    .pclk        (pclk),
    .preset_n    (preset_n),
    .en          (en),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_l        (in_l),
    .in_r        (in_r),
    .bick        (bick),
    .lrck        (lrck),
    .sdata       (sdata),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard and receiver state
  logic [63:0] hold_q[$];
  logic [63:0] exp_q[$];
  logic [63:0] cur_w, prev_w, exp_w, acc_data;
  bit          m_underrun = 0;
  bit          have_prev = 0;
  bit          mon_en = 1;
  bit          acc_s = 0;
  bit          acc_bnd = 0;
  bit          ramp_chk = 0;
  bit          ramp_on = 0;
  bit          fs_valid = 0, rise_valid = 0, fs_rise_pend = 0;
  int          rx_k = 0, cyc = 0, fs_cyc = 0, rise_cyc = 0, acc_cnt = 0, fs_cnt = 0, ramp = 0;
  logic        bick_p = 0, lrck_p = 0, sdata_p = 0;

  // Observe outputs on the falling pclk edge, away from the active edge.
  always @(negedge pclk) begin
    cyc++;
    if (mon_en) begin
      if (frame_start) begin
        if (fs_valid) begin
          check_eq("fs_spacing", 64'(cyc - fs_cyc), 64'(512));
          check_eq("fs_on_bick_fall", 64'(bick_p && !bick), 64'd1);
        end
        fs_cyc = cyc; fs_valid = 1; fs_rise_pend = 1; fs_cnt++;
        if (ramp_chk) begin
          check_eq("accepts_per_frame", 64'(acc_cnt), 64'd1);
          check_eq("accept_in_boundary", 64'(acc_bnd), 64'd1);
        end
        acc_cnt = 0; acc_bnd = 0;
        if (hold_q.size() > 0) exp_q.push_back(hold_q.pop_front());
        else begin
          exp_q.push_back(64'd0);
          m_underrun = 1;
        end
        check_eq("underrun_at_boundary", 64'(underrun), 64'(m_underrun));
        rx_k = 0;
      end
      if (acc_s) begin
        check_eq("hold_overfill", 64'(hold_q.size()), 64'd0);
        hold_q.push_back(acc_data);
        acc_cnt++;
        if (frame_start) acc_bnd = 1;
      end
      if (bick && !bick_p) begin
        if (fs_rise_pend) begin
          check_eq("rise_after_fs", 64'(cyc - fs_cyc), 64'(BCK_HALF));
          fs_rise_pend = 0;
        end
        if (rise_valid) check_eq("bick_period", 64'(cyc - rise_cyc), 64'(2*BCK_HALF));
        rise_cyc = cyc; rise_valid = 1;
        check_eq("lrck_vs_k", 64'(lrck), 64'(rx_k >= int'(DW)));
        if (rx_k == 0) begin
          if (have_prev) begin
            prev_w[0] = sdata;
            check_eq("sb_level", 64'(exp_q.size() > 0), 64'd1);
            exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
            check_eq("frame_data", prev_w, exp_w);
            have_prev = 0;
          end else begin
            check_eq("sdata_first_k0", 64'(sdata), 64'd0);
          end
        end else if (rx_k < int'(FW)) begin
          cur_w[FW-rx_k] = sdata;
        end
        if (rx_k == int'(FW) - 1) begin
          prev_w = cur_w; have_prev = 1;
        end
        rx_k++;
      end
      if (lrck !== lrck_p) check_eq("lrck_on_bick_fall", 64'(bick_p && !bick), 64'd1);
      if (sdata !== sdata_p) check_eq("sdata_on_bick_fall", 64'(bick_p && !bick), 64'd1);
    end
    bick_p = bick; lrck_p = lrck; sdata_p = sdata;
    acc_s = in_valid && in_ready;
    acc_data = {in_l, in_r};
  end

  // Ramp source: present the next pair right after each accepted one.
  always @(posedge pclk) begin
    #1;
    if (ramp_on && acc_s) begin
      ramp++;
      in_l = 32'hA500_0000 + 32'(ramp);
      in_r = 32'h5A00_0000 ^ (32'(ramp) * 32'h0001_0003);
    end
  end

  task automatic tick();
    @(posedge pclk); #1;
  endtask

  task automatic wait_k(input int k);
    int i = 0;
    while (rx_k != k && i < 1500) begin tick(); i++; end
    check_eq("wait_k", 64'(rx_k), 64'(k));
  endtask

  task automatic wait_fs();
    int start = fs_cnt;
    int i = 0;
    while (fs_cnt == start && i < 1500) begin tick(); i++; end
    check_eq("wait_fs", 64'(fs_cnt != start), 64'd1);
  endtask

  task automatic offer_pair(input logic [31:0] l, input logic [31:0] r);
    int i = 0;
    in_l = l; in_r = r; in_valid = 1'b1;
    tick();
    while (!acc_s && i < 1500) begin tick(); i++; end
    check_eq("pair_accepted", 64'(acc_s), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic start_run();
    fs_valid = 0; rise_valid = 0;
    en = 1'b1;
  endtask

  task automatic finish_and_check_idle();
    wait_k(FW);
    repeat (3*BCK_HALF) tick();
    check_eq("idle_bick", 64'(bick), 64'd0);
    check_eq("idle_lrck", 64'(lrck), 64'd0);
    check_eq("idle_sdata", 64'(sdata), 64'd0);
    check_eq("idle_frame_start", 64'(frame_start), 64'd0);
    check_eq("idle_in_ready", 64'(in_ready), 64'(hold_q.size() == 0));
    check_eq("last_frame_done", 64'(have_prev), 64'd1);
    if (have_prev) begin
      exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
      check_eq("last_frame_data", 64'(prev_w[63:1]), 64'(exp_w[63:1]));
      have_prev = 0;
    end
    check_eq("sb_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #2 preset_n = 1'b0;
    repeat (3) tick();
    check_eq("rst_bick", 64'(bick), 64'd0);
    check_eq("rst_lrck", 64'(lrck), 64'd0);
    check_eq("rst_sdata", 64'(sdata), 64'd0);
    check_eq("rst_frame_start", 64'(frame_start), 64'd0);
    check_eq("rst_underrun", 64'(underrun), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    preset_n = 1'b1;
    repeat (2) tick();

    // One pair, then starve the next boundary, then a continuous ramp.
    offer_pair(32'h8000_0001, 32'h7FFF_FFFE);
    start_run();
    wait_fs();
    wait_fs();
    wait_k(20);
    ramp = 0;
    in_l = 32'hA500_0000; in_r = 32'h5A00_0000;
    in_valid = 1'b1; ramp_on = 1;
    wait_fs();
    ramp_chk = 1;
    wait_fs();
    wait_fs();
    // Brief en drop inside a frame must not create a gap.
    wait_k(20); en = 1'b0;
    wait_k(30); en = 1'b1;
    wait_fs();
    check_eq("underrun_sticky", 64'(underrun), 64'd1);
    // Drop en early in the frame; the frame completes before stopping.
    wait_k(10);
    ramp_chk = 0;
    en = 1'b0;
    finish_and_check_idle();
    in_valid = 1'b0; ramp_on = 0;

    // Restart with the held pair, then reset in the middle of the frame.
    start_run();
    wait_fs();
    wait_k(40);
    @(posedge pclk); #3;
    preset_n = 1'b0; mon_en = 0;
    #1;
    check_eq("mid_rst_bick", 64'(bick), 64'd0);
    check_eq("mid_rst_lrck", 64'(lrck), 64'd0);
    check_eq("mid_rst_sdata", 64'(sdata), 64'd0);
    check_eq("mid_rst_frame_start", 64'(frame_start), 64'd0);
    check_eq("mid_rst_underrun", 64'(underrun), 64'd0);
    check_eq("mid_rst_in_ready", 64'(in_ready), 64'd1);
    en = 1'b0; in_valid = 1'b0;
    hold_q.delete(); exp_q.delete();
    m_underrun = 0; have_prev = 0; rx_k = 0; acc_cnt = 0; acc_bnd = 0;
    repeat (4) tick();
    preset_n = 1'b1;
    tick();
    mon_en = 1;

    // Clean restart: one frame with a fresh pair.
    offer_pair(32'h1234_5678, 32'h9ABC_DEF0);
    start_run();
    wait_fs();
    wait_k(5);
    en = 1'b0;
    finish_and_check_idle();
    check_eq("underrun_after_restart", 64'(underrun), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
    $fatal(1);
  end

endmodule
